// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter                                                     |
// | Round-robin IF/DM arbiter sequencing each 16-bit word as two byte    |
// | cycles (high byte at A, low byte at A-1) on a byte-wide async memory. |
// | Optional macro ALIGN_CHECK_EN: even word addresses are rejected.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [2*BYTE_W-1:0] if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [2*BYTE_W-1:0] dm_wdata,
  output logic                dm_ack,
  output logic [2*BYTE_W-1:0] dm_rdata,
  output logic                dm_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [BYTE_W-1:0]   mem_wdata,
  input  logic [BYTE_W-1:0]   mem_rdata
);

  localparam int   c_WORD_W   = 2 * BYTE_W;
  localparam logic c_GRANT_IF = 1'b0;
  localparam logic c_GRANT_DM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // r_last_grant doubles as the owner of the transaction in flight
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [c_WORD_W-1:0] r_wdata;
  logic [BYTE_W-1:0]   r_hi_byte;
  logic [c_WORD_W-1:0] r_if_rdata;
  logic [c_WORD_W-1:0] r_dm_rdata;

  logic                w_any_req;
  logic                w_pick_dm;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_misalign;
  logic                w_grant;

  assign w_any_req  = if_req | dm_req;
  assign w_pick_dm  = dm_req & (~if_req | (r_last_grant == c_GRANT_IF));
  assign w_sel_addr = w_pick_dm ? dm_addr : if_addr;
  assign w_grant    = (r_state == S_IDLE) & w_any_req;

`ifdef ALIGN_CHECK_EN
  logic r_misalign;

  assign w_misalign = ~w_sel_addr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (w_grant) begin
      r_misalign <= w_misalign;
    end
  end

  assign dm_err = dm_ack & r_misalign;
`else
  assign w_misalign = 1'b0;
  assign dm_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and memory-side decode from state plus the latched request
  always_comb begin
    w_next_state = r_state;
    mem_addr     = r_addr;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next_state = w_misalign ? S_ACK : S_HI;
        end
      end
      S_HI: begin
        w_next_state = S_LO;
        mem_wdata    = r_wdata[c_WORD_W-1:BYTE_W];
        mem_we       = r_we;
      end
      S_LO: begin
        w_next_state = S_ACK;
        mem_addr     = r_addr - ADDR_W'(1);
        mem_wdata    = r_wdata[BYTE_W-1:0];
        mem_we       = r_we;
      end
      S_ACK: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= c_GRANT_IF;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
    end else if (w_grant) begin
      r_last_grant <= w_pick_dm ? c_GRANT_DM : c_GRANT_IF;
      r_addr       <= w_sel_addr;
      r_we         <= w_pick_dm & dm_we;
      r_wdata      <= w_pick_dm ? dm_wdata : '0;
    end
  end

  // Low byte goes straight into the port register so rdata is valid during ACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_byte  <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if (!r_we) begin
      if (r_state == S_HI) begin
        r_hi_byte <= mem_rdata;
      end
      if (r_state == S_LO) begin
        if (r_last_grant == c_GRANT_DM) begin
          r_dm_rdata <= {r_hi_byte, mem_rdata};
        end else begin
          r_if_rdata <= {r_hi_byte, mem_rdata};
        end
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign if_ack   = (r_state == S_ACK) & (r_last_grant == c_GRANT_IF);
  assign dm_ack   = (r_state == S_ACK) & (r_last_grant == c_GRANT_DM);
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                  |
// | Directed self-checking bench with a byte-wide async memory model.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [13:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [13:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic        dm_err;
  logic        busy;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:16383] = '{default: 8'h00};
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  int          we_count = 0;

  mem_port_arbiter #(.ADDR_W(14), .BYTE_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] = pl_data;
    else if (mem_we) mem[mem_addr] = mem_wdata;
    if (mem_we) we_count = we_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [13:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic dm_xfer(input logic we, input logic [13:0] a, input logic [15:0] wd,
                         output int lat, output logic [15:0] rd, output logic err);
    lat = -1; rd = '0; err = 1'b0;
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (dm_ack) begin lat = c; rd = dm_rdata; err = dm_err; break; end
    end
    dm_req = 1'b0; dm_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic if_xfer(input logic [13:0] a, output int lat, output logic [15:0] rd);
    lat = -1; rd = '0;
    if_addr = a; if_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (if_ack) begin lat = c; rd = if_rdata; break; end
    end
    if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic both_xfer(input logic [13:0] ia, input logic [13:0] da,
                           output int if_lat, output int dm_lat);
    if_lat = -1; dm_lat = -1;
    if_addr = ia; if_req = 1'b1;
    dm_addr = da; dm_we = 1'b0; dm_req = 1'b1;
    for (int c = 1; c <= 30 && (if_lat < 0 || dm_lat < 0); c++) begin
      @(posedge clk); #1;
      if (if_ack && if_lat < 0) begin if_lat = c; if_req = 1'b0; end
      if (dm_ack && dm_lat < 0) begin dm_lat = c; dm_req = 1'b0; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int lat; logic [15:0] rd; logic err;
    dm_xfer(1'b1, 14'h0011, 16'hBEEF, lat, rd, err);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    checks++; if (mem[14'h0011] !== 8'hBE) begin errors++; $display("FAIL wr_hi_byte: got %h want be", mem[14'h0011]); end
    checks++; if (mem[14'h0010] !== 8'hEF) begin errors++; $display("FAIL wr_lo_byte: got %h want ef", mem[14'h0010]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", err); end
    if_xfer(14'h0011, lat, rd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL if_latency: got %0d want 3", lat); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL if_rdata: got %h want beef", rd); end
    dm_xfer(1'b0, 14'h0011, 16'h0000, lat, rd, err);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL dm_rdata: got %h want beef", rd); end
    checks++; if (if_rdata !== 16'hBEEF) begin errors++; $display("FAIL if_rdata_hold: got %h want beef", if_rdata); end
  endtask

  task automatic test_reset;
    int ack_seen = 0;
    rst_n = 1'b0; #2;
    checks++;
    if ({if_ack, dm_ack, dm_err, busy, mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {if_ack, dm_ack, dm_err, busy, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 22'h0) begin
      errors++; $display("FAIL reset_mem_bus: got addr %h data %h want 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({if_rdata, dm_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got if %h dm %h want 0", if_rdata, dm_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (if_ack || dm_ack || busy) ack_seen++;
    end
    checks++; if (ack_seen !== 0) begin errors++; $display("FAIL reset_release_idle: got %0d active cycles want 0", ack_seen); end
  endtask

  task automatic test_conflict;
    int il, dl, lat; logic [15:0] rd; logic err;
    poke(14'h0101, 8'h11); poke(14'h0100, 8'h22);
    poke(14'h0201, 8'h33); poke(14'h0200, 8'h44);
    both_xfer(14'h0101, 14'h0201, il, dl);
    checks++; if (dl !== 3 || il !== 7) begin errors++; $display("FAIL conflict1: got dm %0d if %0d want dm 3 if 7", dl, il); end
    checks++; if (dm_rdata !== 16'h3344 || if_rdata !== 16'h1122) begin
      errors++; $display("FAIL conflict1_data: got dm %h if %h want 3344 1122", dm_rdata, if_rdata);
    end
    both_xfer(14'h0101, 14'h0201, il, dl);
    checks++; if (dl !== 3 || il !== 7) begin errors++; $display("FAIL conflict2: got dm %0d if %0d want dm 3 if 7", dl, il); end
    dm_xfer(1'b0, 14'h0101, 16'h0000, lat, rd, err);
    checks++; if (rd !== 16'h1122) begin errors++; $display("FAIL dm_only_read: got %h want 1122", rd); end
    both_xfer(14'h0201, 14'h0101, il, dl);
    checks++; if (il !== 3 || dl !== 7) begin errors++; $display("FAIL conflict3: got if %0d dm %0d want if 3 dm 7", il, dl); end
    checks++; if (if_rdata !== 16'h3344) begin errors++; $display("FAIL conflict3_data: got %h want 3344", if_rdata); end
  endtask

`ifndef ALIGN_CHECK_EN
  task automatic test_wrap;
    int lat; logic [15:0] rd; logic err;
    dm_xfer(1'b1, 14'h0000, 16'h1234, lat, rd, err);
    checks++; if (mem[14'h0000] !== 8'h12) begin errors++; $display("FAIL wrap_hi: got %h want 12", mem[14'h0000]); end
    checks++; if (mem[14'h3FFF] !== 8'h34) begin errors++; $display("FAIL wrap_lo: got %h want 34", mem[14'h3FFF]); end
    dm_xfer(1'b0, 14'h0000, 16'h0000, lat, rd, err);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL wrap_read: got %h want 1234", rd); end
  endtask
`endif

  task automatic test_reset_mid;
    int ack_seen = 0;
    poke(14'h0021, 8'h00); poke(14'h0020, 8'h5A);
    dm_we = 1'b1; dm_addr = 14'h0021; dm_wdata = 16'hA5C3; dm_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 14'h0021, 8'hA5}) begin
      errors++; $display("FAIL mid_hi_bus: got busy %b we %b addr %h data %h want 1 1 0021 a5", busy, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 14'h0020, 8'hC3}) begin
      errors++; $display("FAIL mid_lo_bus: got we %b addr %h data %h want 1 0020 c3", mem_we, mem_addr, mem_wdata);
    end
    rst_n = 1'b0; dm_req = 1'b0; dm_we = 1'b0; #1;
    checks++; if ({busy, mem_we, dm_ack} !== 3'b000) begin errors++; $display("FAIL mid_abort: got %b want 000", {busy, mem_we, dm_ack}); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (dm_ack) ack_seen++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (dm_ack) ack_seen++;
    checks++; if (ack_seen !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d acks want 0", ack_seen); end
    checks++; if (mem[14'h0021] !== 8'hA5) begin errors++; $display("FAIL mid_hi_written: got %h want a5", mem[14'h0021]); end
    checks++; if (mem[14'h0020] !== 8'h5A) begin errors++; $display("FAIL mid_lo_kept: got %h want 5a", mem[14'h0020]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got busy %b want 0", busy); end
  endtask

`ifdef ALIGN_CHECK_EN
  task automatic test_align;
    int lat, w0; logic [15:0] rd; logic err;
    poke(14'h0010, 8'h77); poke(14'h000F, 8'h66);
    w0 = we_count;
    dm_xfer(1'b1, 14'h0010, 16'hFFFF, lat, rd, err);
    checks++; if (lat !== 1) begin errors++; $display("FAIL align_latency: got %0d want 1", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL align_err: got %b want 1", err); end
    checks++; if (we_count !== w0) begin errors++; $display("FAIL align_no_we: got %0d strobes want 0", we_count - w0); end
    checks++; if (mem[14'h0010] !== 8'h77 || mem[14'h000F] !== 8'h66) begin
      errors++; $display("FAIL align_mem: got %h %h want 77 66", mem[14'h0010], mem[14'h000F]);
    end
    if_xfer(14'h0010, lat, rd);
    checks++; if (lat !== 1 || rd !== 16'h0000) begin errors++; $display("FAIL align_if: got lat %0d data %h want 1 0000", lat, rd); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_write_read;
    test_reset;
    test_conflict;
`ifndef ALIGN_CHECK_EN
    test_wrap;
`endif
    test_reset_mid;
`ifdef ALIGN_CHECK_EN
    test_align;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
